// File: rtl/safe.sv
// Keypad safe controller: synchronizes a scanned 4x3 keypad, debounces per key,
// collects up to six digits and sequences open/retry/lockout/re-program states.
module safe (
   input  logic       clk,
   input  logic       initialize,
   input  logic       row1,
   input  logic       row2,
   input  logic       row3,
   input  logic       row4,
   input  logic       col1,
   input  logic       col2,
   input  logic       col3,
   input  logic       reset_password,
   output logic [5:0] password_led,
   output logic [2:0] state
);

   // state    | meaning
   // S_OFF    | idle, waiting for '*'
   // S_ON     | entry, three tries left
   // S_WRONG1 | entry, two tries left
   // S_WRONG2 | entry, one try left
   // S_OPEN   | unlocked
   // S_RESET  | entering a new password
   // S_LOCK   | locked out until initialize
   typedef enum logic [2:0] {
      S_OFF    = 3'd0,
      S_ON     = 3'd1,
      S_WRONG1 = 3'd2,
      S_WRONG2 = 3'd3,
      S_OPEN   = 3'd4,
      S_RESET  = 3'd5,
      S_LOCK   = 3'd7
   } state_t;

   state_t      state_q, state_next;
   logic [7:0]  sync1, sync2;
   logic [11:0] flags, flags_next, key_hit;
   logic        rp_prev, rp_edge, key_valid, is_digit, is_star, is_hash;
   logic        match, clear_entry, append, store_pw;
   logic [3:0]  key_code;
   logic [2:0]  count, count_next, pw_len;
   logic [3:0]  entry [0:5];
   logic [3:0]  pw [0:5];
   logic [3:0]  rows;
   logic [2:0]  cols;
   logic        valid;

   function automatic logic [3:0] key_value(input int k);
      case (k)
         9:       key_value = 4'd10;
         10:      key_value = 4'd0;
         11:      key_value = 4'd11;
         default: key_value = 4'(k + 1);
      endcase
   endfunction

   function automatic logic [5:0] thermo(input logic [2:0] n);
      thermo = '0;
      for (int i = 0; i < 6; i++)
         thermo[5-i] = (3'(i) < n);
   endfunction

   assign rows    = sync2[3:0];
   assign cols    = sync2[6:4];
   assign rp_edge = sync2[7] & ~rp_prev;
   assign state   = state_q;

   // Cycles with several rows or several columns high are ghosting; drop them entirely.
   assign valid = ~(|(rows & (rows - 4'd1))) & ~(|(cols & (cols - 3'd1)));

   always_comb begin
      flags_next = flags;
      key_hit    = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (valid && rows[r]) begin
               if (cols[c] && !flags[r*3+c]) begin
                  key_hit[r*3+c]    = 1'b1;
                  flags_next[r*3+c] = 1'b1;
               end else if (!cols[c]) begin
                  flags_next[r*3+c] = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      key_code = '0;
      for (int k = 0; k < 12; k++)
         if (key_hit[k]) key_code = key_value(k);
   end

   assign key_valid = |key_hit;
   assign is_digit  = key_valid && (key_code < 4'd10);
   assign is_star   = key_valid && (key_code == 4'd10);
   assign is_hash   = key_valid && (key_code == 4'd11);

   always_comb begin
      match = (count == pw_len);
      for (int i = 0; i < 6; i++)
         if ((3'(i) < count) && (entry[i] != pw[i])) match = 1'b0;
   end

   always_ff @(posedge clk or posedge initialize) begin
      if (initialize) state_q <= S_OFF;
      else            state_q <= state_next;
   end

   always_comb begin
      state_next = state_q;
      case (state_q)
         S_OFF:    if (is_star) state_next = S_ON;
         S_ON:     if (is_hash) state_next = match ? S_OPEN : S_WRONG1;
         S_WRONG1: if (is_hash) state_next = match ? S_OPEN : S_WRONG2;
         S_WRONG2: if (is_hash) state_next = match ? S_OPEN : S_LOCK;
         S_OPEN: begin
            if (rp_edge)      state_next = S_RESET;
            else if (is_star) state_next = S_OFF;
         end
         S_RESET:  if (is_hash && count != 3'd0) state_next = S_ON;
         S_LOCK:   state_next = S_LOCK;
         default:  state_next = S_OFF;
      endcase
   end

   always_comb begin
      clear_entry = is_star || is_hash || (state_next != state_q);
      append      = is_digit && !clear_entry && (count < 3'd6) &&
                    (state_q inside {S_ON, S_WRONG1, S_WRONG2, S_RESET});
      store_pw    = (state_q == S_RESET) && is_hash && (count != 3'd0);
      if (clear_entry) count_next = 3'd0;
      else if (append) count_next = count + 3'd1;
      else             count_next = count;
   end

   always_ff @(posedge clk or posedge initialize) begin
      if (initialize) begin
         sync1        <= '0;
         sync2        <= '0;
         rp_prev      <= 1'b0;
         flags        <= '0;
         count        <= '0;
         password_led <= '0;
         pw_len       <= 3'd4;
         for (int i = 0; i < 6; i++) begin
            entry[i] <= '0;
            pw[i]    <= (i < 4) ? 4'(i + 1) : 4'd0;
         end
      end else begin
         sync1        <= {reset_password, col3, col2, col1, row4, row3, row2, row1};
         sync2        <= sync1;
         rp_prev      <= sync2[7];
         flags        <= flags_next;
         count        <= count_next;
         password_led <= thermo(count_next);
         if (append) entry[count] <= key_code;
         if (store_pw) begin
            pw_len <= count;
            for (int i = 0; i < 6; i++) pw[i] <= entry[i];
         end
      end
   end

endmodule

// File: tb/tb_safe.sv
// Bench for the keypad safe: spec-derived vector table, hand-built corner
// sequences, then random keys checked against a digit-queue model.
module tb_safe;
   logic       clk = 1'b0;
   logic       initialize = 1'b1;
   logic [3:0] rows = '0;
   logic [2:0] cols = '0;
   logic       rp = 1'b0;
   logic [5:0] password_led;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;

   safe dut (
      .clk(clk), .initialize(initialize),
      .row1(rows[0]), .row2(rows[1]), .row3(rows[2]), .row4(rows[3]),
      .col1(cols[0]), .col2(cols[1]), .col3(cols[2]),
      .reset_password(rp), .password_led(password_led), .state(state)
   );

   always #5 clk = ~clk;

   // keys: 0..9 digits, 10 = '*', 11 = '#'
   int mstate;
   int mbuf[$];
   int mpw[$];

   function automatic logic [5:0] led_of(input int n);
      logic [5:0] t;
      t = '0;
      for (int i = 0; i < n; i++) t[5-i] = 1'b1;
      return t;
   endfunction

   function automatic bit same_code();
      if (mbuf.size() != mpw.size()) return 1'b0;
      foreach (mbuf[i]) if (mbuf[i] != mpw[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void model_init();
      mstate = 0;
      mbuf.delete();
      mpw = '{1, 2, 3, 4};
   endfunction

   function automatic void model_key(input int k);
      case (mstate)
         0: if (k == 10) mstate = 1;
         1, 2, 3: begin
            if (k < 10) begin
               if (mbuf.size() < 6) mbuf.push_back(k);
            end else begin
               if (k == 11) begin
                  if (same_code()) mstate = 4;
                  else mstate = (mstate == 3) ? 7 : mstate + 1;
               end
               mbuf.delete();
            end
         end
         4: if (k == 10) mstate = 0;
         5: begin
            if (k < 10) begin
               if (mbuf.size() < 6) mbuf.push_back(k);
            end else begin
               if (k == 11 && mbuf.size() > 0) begin
                  mpw = mbuf;
                  mstate = 1;
               end
               mbuf.delete();
            end
         end
         default: ;
      endcase
   endfunction

   function automatic void model_rp();
      if (mstate == 4) begin
         mstate = 5;
         mbuf.delete();
      end
   endfunction

   task automatic check(input string name, input int exp_st, input logic [5:0] exp_led);
      total++;
      if (state != 3'(exp_st) || password_led != exp_led) begin
         bad++;
         $display("FAIL %s: state=%0d led=%b, required state=%0d led=%b",
                  name, state, password_led, exp_st, exp_led);
      end
   endtask

   task automatic press(input int k);
      int r, c;
      if (k >= 1 && k <= 9) begin r = (k - 1) / 3; c = (k - 1) % 3; end
      else begin r = 3; c = (k == 10) ? 0 : (k == 0) ? 1 : 2; end
      @(negedge clk);
      rows = 4'(1 << r);
      cols = 3'(1 << c);
      repeat (3) @(negedge clk);
      cols = '0;
      repeat (3) @(negedge clk);
      rows = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_key(input int k);
      press(k);
      model_key(k);
   endtask

   task automatic do_rp();
      @(negedge clk);
      rp = 1'b1;
      repeat (4) @(negedge clk);
      rp = 1'b0;
      repeat (4) @(negedge clk);
      model_rp();
   endtask

   task automatic do_init();
      @(negedge clk);
      initialize = 1'b1;
      repeat (2) @(negedge clk);
      initialize = 1'b0;
      repeat (2) @(negedge clk);
      model_init();
   endtask

   typedef struct {
      int         op;   // 0 key, 1 reset_password pulse, 2 initialize
      int         arg;
      int         st;
      logic [5:0] led;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input int op, input int arg, input int st, input logic [5:0] led);
      vec_t v;
      v.op = op; v.arg = arg; v.st = st; v.led = led;
      tbl.push_back(v);
   endtask

   initial begin
      model_init();
      #1 check("reset", 0, 6'b000000);
      repeat (2) @(negedge clk);
      initialize = 1'b0;
      repeat (2) @(negedge clk);

      add(0, 10, 1, 6'b000000);
      add(0, 1, 1, 6'b100000); add(0, 2, 1, 6'b110000);
      add(0, 3, 1, 6'b111000); add(0, 4, 1, 6'b111100);
      add(0, 11, 4, 6'b000000);
      add(0, 10, 0, 6'b000000); add(0, 10, 1, 6'b000000);
      add(0, 9, 1, 6'b100000);  add(0, 11, 2, 6'b000000);
      add(0, 9, 2, 6'b100000);  add(0, 11, 3, 6'b000000);
      add(0, 9, 3, 6'b100000);  add(0, 11, 7, 6'b000000);
      add(0, 1, 7, 6'b000000);  add(0, 2, 7, 6'b000000);
      add(0, 3, 7, 6'b000000);  add(0, 4, 7, 6'b000000);
      add(0, 11, 7, 6'b000000);
      add(2, 0, 0, 6'b000000);  add(0, 10, 1, 6'b000000);
      add(0, 1, 1, 6'b100000);  add(0, 2, 1, 6'b110000);
      add(0, 3, 1, 6'b111000);  add(0, 11, 2, 6'b000000);
      add(0, 1, 2, 6'b100000);  add(0, 2, 2, 6'b110000);
      add(0, 3, 2, 6'b111000);  add(0, 4, 2, 6'b111100);
      add(0, 5, 2, 6'b111110);  add(0, 11, 3, 6'b000000);
      add(0, 1, 3, 6'b100000);  add(0, 2, 3, 6'b110000);
      add(0, 3, 3, 6'b111000);  add(0, 4, 3, 6'b111100);
      add(0, 11, 4, 6'b000000);
      add(0, 1, 4, 6'b000000);
      add(1, 0, 5, 6'b000000);
      add(0, 11, 5, 6'b000000);
      add(0, 5, 5, 6'b100000);  add(0, 6, 5, 6'b110000);
      add(0, 11, 1, 6'b000000);
      add(0, 1, 1, 6'b100000);  add(0, 2, 1, 6'b110000);
      add(0, 3, 1, 6'b111000);  add(0, 4, 1, 6'b111100);
      add(0, 11, 2, 6'b000000);
      add(0, 5, 2, 6'b100000);  add(0, 6, 2, 6'b110000);
      add(0, 11, 4, 6'b000000);
      add(0, 10, 0, 6'b000000); add(0, 10, 1, 6'b000000);
      add(0, 1, 1, 6'b100000);  add(0, 2, 1, 6'b110000);
      add(0, 3, 1, 6'b111000);  add(0, 4, 1, 6'b111100);
      add(0, 5, 1, 6'b111110);  add(0, 6, 1, 6'b111111);
      add(0, 7, 1, 6'b111111);  add(0, 10, 1, 6'b000000);

      foreach (tbl[i]) begin
         case (tbl[i].op)
            0: do_key(tbl[i].arg);
            1: do_rp();
            default: do_init();
         endcase
         check($sformatf("vec%0d", i), tbl[i].st, tbl[i].led);
      end

      // key 5 held across three full scan rounds, then released
      for (int round = 0; round < 4; round++) begin
         for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            rows = 4'(1 << r);
            cols = (r == 1 && round < 3) ? 3'b010 : 3'b000;
            repeat (3) @(negedge clk);
         end
      end
      rows = '0; cols = '0;
      repeat (3) @(negedge clk);
      model_key(5);
      check("hold5", 1, 6'b100000);
      do_key(10);

      // keys 1 and 2 together: ghosting cycle, no event
      @(negedge clk);
      rows = 4'b0001; cols = 3'b011;
      repeat (4) @(negedge clk);
      cols = '0;
      repeat (3) @(negedge clk);
      rows = '0;
      repeat (3) @(negedge clk);
      check("multi_key", 1, 6'b000000);

      // stored password is 5,6 here; open, then reset_password together with '*'
      do_key(5); do_key(6); do_key(11);
      check("open56", 4, 6'b000000);
      @(negedge clk);
      rows = 4'b1000; cols = 3'b001; rp = 1'b1;
      repeat (3) @(negedge clk);
      cols = '0;
      repeat (3) @(negedge clk);
      rows = '0; rp = 1'b0;
      repeat (3) @(negedge clk);
      model_rp();
      check("rp_wins", 5, 6'b000000);

      // initialize mid-RESET discards the partial new password
      do_key(7); do_key(7);
      check("reset_entry", 5, 6'b110000);
      @(negedge clk);
      initialize = 1'b1;
      #1 check("init_async", 0, 6'b000000);
      repeat (2) @(negedge clk);
      initialize = 1'b0;
      repeat (2) @(negedge clk);
      model_init();
      do_key(10); do_key(1); do_key(2); do_key(3); do_key(4); do_key(11);
      check("default_pw", 4, 6'b000000);

      for (int n = 0; n < 300; n++) begin
         int sel;
         sel = $urandom_range(0, 99);
         if (sel < 4) do_init();
         else if (sel < 14) do_rp();
         else if (sel < 30) begin
            int code[$];
            code = mpw;
            if (mstate == 0) do_key(10);
            foreach (code[i]) do_key(code[i]);
            do_key(11);
         end else do_key($urandom_range(0, 11));
         check($sformatf("rand%0d", n), mstate, led_of(mbuf.size()));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/safe.md
# safe

Keypad-driven digital safe controller. Decodes a 4-row by 3-column scanned keypad, collects up to 6-digit codes, and compares them against a stored password. Tracks remaining attempts, the open state, password re-programming and lockout. Sits under the board top-level, which drives the row scan, and reports `state` and `password_led` to the 7-segment and LED display logic.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on the rising edge.
- initialize  input  1  reset; asynchronous, active-high; full initialization.
- row1..row4  input  1 each  keypad row strobes, one-hot, driven by the external scanner (≈1 M cycles per row).
- col1..col3  input  1 each  keypad column returns.
- reset_password  input  1  password-change button, level.
- password_led  output  6  digit-entry progress, thermometer from bit 5 downward.
- state  output  3  controller state code.

## Operation
- Key map (row, col): r1 = 1,2,3; r2 = 4,5,6; r3 = 7,8,9; r4 = `*`,0,`#`.
- All keypad and button inputs pass through a 2-flop synchronizer.
- Per-key press flag (12 flags):
  - Press event: the key's row is high, its column is high, and its flag is clear. The flag is then set.
  - Release: the flag clears when the key's row is high and its column is low.
- Invalid cycles: if more than one row or more than one column is high in a cycle, that cycle produces no events and no flag updates.
- reset_password acts on the rising edge of its synchronized value.
- Stored password: 6 digits × 4 bits plus a 3-bit length (1..6). After initialize it is `1,2,3,4` with length 4.
- Entry buffer: 6 digits plus a 3-bit count.
  - A digit key appends a digit when count < 6. Further digits are ignored.
  - `password_led` bit (5−i) = 1 for i < count. Example: count 2 gives 110000.
- States:
  - 0 OFF: `*` → ON; all else ignored.
  - 1 ON (3 tries): digits append; `*` clears the entry; `#` compares the entry.
  - 2 WRONG1 (2 tries): same behaviour as ON.
  - 3 WRONG2 (1 try): same behaviour as ON.
  - 4 OPEN: reset_password edge → RESET; `*` → OFF; digits and `#` ignored.
  - 5 RESET: digits append; `*` clears the entry.
    - `#` with count ≥ 1: store entry as the new password and length, then → ON.
    - `#` with count 0: ignored.
  - 7 LOCK: absorbing; exits only on initialize.
  - Code 6 is never produced.
- Compare on `#`: match requires equal length and equal digits.
  - Match → OPEN.
  - Mismatch: 1→2, 2→3, 3→7.
  - `#` with count 0 counts as a mismatch.
- The entry buffer and `password_led` clear on `#`, on `*`, and on every state change.
- reset_password is ignored outside OPEN.

## Timing
- Reset values on initialize (immediate, asynchronous):
  - `state` = 0, `password_led` = 000000.
  - Entry cleared, key flags cleared, synchronizers cleared.
  - Password = 1234.
- Outputs are registered.
- Latency: an input change set up before rising edge N is reflected on `state` / `password_led` after rising edge N+2 (2 synchronizer stages, then the update).
- One key event is processed per cycle. A held key produces exactly one event until released. Re-press after release produces a new event.
- reset_password high at the same time as a key event in OPEN: reset_password wins (→ RESET) and the key is dropped.
- initialize mid-entry or mid-RESET discards everything, including a partially entered new password. The stored password reverts to 1234.

## Test plan
- Initialize, press `*` → state 1. Press 1,2,3,4 → `password_led` 100000, 110000, 111000, 111100. Press `#` → state 4, `password_led` 000000.
- From state 1, enter 9,`#` three times → state 2, then 3, then 7. Then enter 1,2,3,4,`#` → state stays 7. Assert initialize → state 0.
- Enter 1,2,3 then `#` → state 2 (length mismatch). Enter 1,2,3,4,5 then `#` → state 3.
- In OPEN, pulse reset_password → state 5. Enter 5,6 then `#` → state 1. Enter 1,2,3,4,`#` → state 2. Enter 5,6,`#` → state 4.
- Enter 7 digits → `password_led` saturates at 111111. Press `*` → 000000. Hold key 5 for 3 full scan rounds → count increments once.
- Press keys 1 and 2 simultaneously (row1, col1 and col2 high) → no change. Assert initialize mid-RESET → state 0 and password 1234 still opens the safe.
